dcache: RTL and testbench
=========================

# dcache

Write-back, direct-mapped data cache that answers the datapath's memory-stage requests (dmemREN/dmemWEN/dmemaddr/dmemstore) with dhit/dmemload. It sits between the pipeline's data port and the memory controller's data port. Misses are served with two-word block fills from memory, with write-back of dirty victims first. On halt it flushes every dirty block to memory, then raises flushed.

## Interface
- IDX_W, default 3: index width; SETS = 2^IDX_W frames of 2 words each.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- halt  in  1  datapath halted; starts the flush; sampled in IDLE only.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request; has priority over dmemREN.
- dmemaddr  in  32  word address. Fields: tag [31:3+IDX_W], index [2+IDX_W:3], block offset [2], byte [1:0] (ignored).
- dmemstore  in  32  store data.
- dhit  out  1  request completed this cycle.
- dmemload  out  32  load data, valid when dhit.
- flushed  out  1  flush complete; sticky until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address (bits [1:0] = 0).
- dstore  out  32  memory write data.
- dload  in  32  memory read data, valid when dREN && !dwait.
- dwait  in  1  memory busy; a transfer completes in a cycle where the request is high and dwait = 0.

## Operation
- Per frame: valid, dirty, tag, word0, word1. Reset clears all valid/dirty/tag/data bits.
- Hit = state IDLE && !halt && (dmemREN||dmemWEN) && valid[idx] && tag[idx]==addr tag.
- IDLE state:
  - halt=1: go to FL_CHK with flush index 0. Pending requests are ignored and dhit=0.
  - Read hit: dhit=1, dmemload=word[offset], combinational.
  - Write hit: dhit=1; at the edge, word[offset] <= dmemstore and dirty <= 1.
  - Miss: go to WB0 if valid&&dirty, else LD0.
- WB0: dWEN=1, daddr={victim tag, idx, 3'b000}, dstore=word0. On !dwait, go to WB1.
- WB1: same, daddr offset 3'b100, dstore=word1. On !dwait, go to LD0.
- LD0: dREN=1, daddr={req tag, idx, 3'b000}. On !dwait, word0 <= dload, go to LD1.
- LD1: dREN=1, offset 3'b100. On !dwait:
  - word1 <= dload, tag <= req tag, valid <= 1, dirty <= 0.
  - Go to IDLE; the still-asserted request then hits.
- FL_CHK: if valid&&dirty of frame[fidx], go to FL0. Else if fidx==SETS-1, go to DONE. Else fidx++.
- FL0/FL1: write word0/word1 of frame[fidx] as in WB0/WB1. On FL1 completion, dirty <= 0; then go to DONE if fidx==SETS-1, else fidx++ and return to FL_CHK.
- DONE: flushed=1, all memory requests 0, dhit=0. Terminal until reset.
- Outputs outside the states named above are 0 (dREN, dWEN, daddr, dstore, dhit, dmemload).
- The request inputs must stay stable while a miss is being served. If they change mid-miss, the fill still completes for the original address latched at miss entry.

## Timing
- Reset values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, state IDLE, fidx=0.
- Hit: 0-cycle latency, dhit in the request cycle.
- Clean miss with dwait=0: request in cycle 0 → LD0 in c1 → LD1 in c2 → dhit in c3.
- Dirty miss with dwait=0: WB0 c1, WB1 c2, LD0 c3, LD1 c4, dhit c5.
- Each cycle of dwait=1 stalls the current transfer by one cycle. Outputs are held stable while dwait=1.
- Flush with no dirty frames: SETS cycles in FL_CHK, then DONE.
- Asynchronous reset mid-transaction drops the transfer immediately and returns to the reset state; the cache is then invalid.

## Test plan
- Reset, then read 0x00000040 with dload=0xDEADBEEF (word0) and 0xCAFEF00D (word1), dwait=0: dREN in c1-c2 with daddr 0x40 then 0x44; dhit in c3 with dmemload=0xDEADBEEF. An immediate read of 0x44 hits the same cycle with 0xCAFEF00D.
- Write 0x12345678 to 0x40 after the fill: dhit the same cycle, no memory traffic.
- Read 0x00000080 (same index 0, new tag): WB0/WB1 with daddr 0x40/0x44 and dstore 0x12345678/0xCAFEF00D, then fill 0x80/0x84; dhit in c5.
- Hold dwait=1 for 3 cycles during LD0: dREN and daddr stay stable, word0 is captured only on the dwait=0 cycle, dhit is 3 cycles late.
- Dirty frames at indexes 2 and 5, then halt=1: writes go to exactly those four addresses in index order, then flushed=1 and stays high. halt is ignored during a miss until IDLE.
- Assert nRST=0 during WB1: all outputs drop to reset values asynchronously, and a later read of a previously cached address misses.

Source files
------------

// File: rtl/dcache.sv
// dcache: write-back, direct-mapped data cache with two-word blocks.
//
// Serves datapath loads/stores (dmemREN/dmemWEN/dmemaddr/dmemstore) with a
// combinational hit path (dhit/dmemload). Misses write back a dirty victim
// (WB0/WB1) and then fill the block (LD0/LD1) over the memory port. On halt,
// every dirty frame is written back in index order, then flushed is raised.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   halt                 start flush (sampled in IDLE only)
//   dmemREN, dmemWEN     datapath load/store request (store has priority)
//   dmemaddr, dmemstore  request word address and store data
//   dhit, dmemload       request completed this cycle, load data
//   flushed              flush complete (sticky until reset)
//   dREN, dWEN           memory read/write request
//   daddr, dstore        memory word address and write data
//   dload, dwait         memory read data, memory busy
module dcache #(
  parameter int IDX_W = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = 29 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FL_CHK, FL0, FL1, DONE
  } state_t;

  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_fidx;
  logic [IDX_W-1:0]    r_req_idx;
  logic [TAG_W-1:0]    r_req_tag;
  logic [SETS-1:0]     r_valid;
  logic [SETS-1:0]     r_dirty;
  logic [TAG_W-1:0]    r_tag   [SETS];
  logic [31:0]         r_word0 [SETS];
  logic [31:0]         r_word1 [SETS];

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic                w_off;
  logic                w_req;
  logic                w_hit;
  logic                w_miss;
  logic                w_unused;

  assign w_tag    = dmemaddr[31:3+IDX_W];
  assign w_idx    = dmemaddr[2+IDX_W:3];
  assign w_off    = dmemaddr[2];
  assign w_req    = dmemREN | dmemWEN;
  assign w_unused = &{1'b0, dmemaddr[1:0]};

  assign w_hit  = (r_state == IDLE) && !halt && w_req &&
                  r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == IDLE) && !halt && w_req && !w_hit;

  // Next state and all outputs; memory-side addresses come from latched
  // request fields so a mid-miss input change cannot redirect the fill.
  always_comb begin
    w_next   = r_state;
    dhit     = 1'b0;
    dmemload = 32'h0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    case (r_state)
      IDLE: begin
        if (halt) begin
          w_next = FL_CHK;
        end else if (w_hit) begin
          dhit = 1'b1;
          if (!dmemWEN) dmemload = w_off ? r_word1[w_idx] : r_word0[w_idx];
        end else if (w_req) begin
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WB0 : LD0;
        end
      end
      WB0: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_req_idx], r_req_idx, 3'b000};
        dstore = r_word0[r_req_idx];
        if (!dwait) w_next = WB1;
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_req_idx], r_req_idx, 3'b100};
        dstore = r_word1[r_req_idx];
        if (!dwait) w_next = LD0;
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = {r_req_tag, r_req_idx, 3'b000};
        if (!dwait) w_next = LD1;
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = {r_req_tag, r_req_idx, 3'b100};
        if (!dwait) w_next = IDLE;
      end
      FL_CHK: begin
        if (r_valid[r_fidx] && r_dirty[r_fidx]) w_next = FL0;
        else if (r_fidx == LAST_IDX)            w_next = DONE;
      end
      FL0: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_fidx], r_fidx, 3'b000};
        dstore = r_word0[r_fidx];
        if (!dwait) w_next = FL1;
      end
      FL1: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[r_fidx], r_fidx, 3'b100};
        dstore = r_word1[r_fidx];
        if (!dwait) w_next = (r_fidx == LAST_IDX) ? DONE : FL_CHK;
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_fidx    <= '0;
      r_req_idx <= '0;
      r_req_tag <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_tag[i]   <= '0;
        r_word0[i] <= '0;
        r_word1[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (halt) begin
            r_fidx <= '0;
          end else if (w_hit && dmemWEN) begin
            if (w_off) r_word1[w_idx] <= dmemstore;
            else       r_word0[w_idx] <= dmemstore;
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_req_idx <= w_idx;
            r_req_tag <= w_tag;
          end
        end
        LD0: if (!dwait) r_word0[r_req_idx] <= dload;
        LD1: begin
          if (!dwait) begin
            r_word1[r_req_idx] <= dload;
            r_tag[r_req_idx]   <= r_req_tag;
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
          end
        end
        FL_CHK: begin
          if (!(r_valid[r_fidx] && r_dirty[r_fidx]) && (r_fidx != LAST_IDX))
            r_fidx <= r_fidx + 1'b1;
        end
        FL1: begin
          if (!dwait) begin
            r_dirty[r_fidx] <= 1'b0;
            if (r_fidx != LAST_IDX) r_fidx <= r_fidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

  logic        CLK;
  logic        nRST;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  int n_checks = 0;
  int n_errors = 0;

  // Memory image (read-only); returns junk while stalled so early capture shows.
  logic [31:0] mem [0:255];
  assign dload = dwait ? 32'hBADBAD00 : mem[daddr[9:2]];

  // Log of completed memory writes.
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;

  always @(posedge CLK) begin
    if (nRST && dWEN && !dwait && wr_cnt < 64) begin
      wr_addr[wr_cnt] <= daddr;
      wr_data[wr_cnt] <= dstore;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  dcache #(.IDX_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  int base;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;  mem[17] = 32'hCAFEF00D;   // 0x40 / 0x44
    mem[20] = 32'h50505050;  mem[21] = 32'h54545454;   // 0x50 / 0x54
    mem[26] = 32'h68686868;  mem[27] = 32'h6C6C6C6C;   // 0x68 / 0x6C
    mem[32] = 32'h11110000;  mem[33] = 32'h22221111;   // 0x80 / 0x84
    mem[48] = 32'h33333333;  mem[49] = 32'h44444444;   // 0xC0 / 0xC4
    mem[64] = 32'h10010000;  mem[65] = 32'h10410000;   // 0x100 / 0x104

    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = 32'h0; dmemstore = 32'h0; dwait = 1'b0;

    // Reset state
    step(); step(); settle();
    check_eq("rst_dhit",     dhit,     0);
    check_eq("rst_dmemload", dmemload, 0);
    check_eq("rst_flushed",  flushed,  0);
    check_eq("rst_dREN",     dREN,     0);
    check_eq("rst_dWEN",     dWEN,     0);
    check_eq("rst_daddr",    daddr,    0);
    check_eq("rst_dstore",   dstore,   0);
    step(); nRST = 1'b1;

    // Clean miss on 0x40
    step(); dmemREN = 1'b1; dmemaddr = 32'h40; settle();
    check_eq("t1_c0_dhit", dhit, 0);
    step(); settle();
    check_eq("t1_c1_dREN", dREN, 1);
    check_eq("t1_c1_daddr", daddr, 32'h40);
    step(); settle();
    check_eq("t1_c2_dREN", dREN, 1);
    check_eq("t1_c2_daddr", daddr, 32'h44);
    step(); settle();
    check_eq("t1_c3_dhit", dhit, 1);
    check_eq("t1_c3_load", dmemload, 32'hDEADBEEF);
    check_eq("t1_c3_dREN", dREN, 0);
    step(); dmemaddr = 32'h44; settle();
    check_eq("t1_w1_dhit", dhit, 1);
    check_eq("t1_w1_load", dmemload, 32'hCAFEF00D);

    // Write hit on 0x40
    step(); dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'h12345678; settle();
    check_eq("t2_dhit", dhit, 1);
    check_eq("t2_dREN", dREN, 0);
    check_eq("t2_dWEN", dWEN, 0);
    step(); dmemWEN = 1'b0; dmemREN = 1'b1; settle();
    check_eq("t2_readback", dmemload, 32'h12345678);

    // Dirty miss on 0x80: write back 0x40/0x44 then fill
    step(); dmemaddr = 32'h80; base = wr_cnt; settle();
    check_eq("t3_c0_dhit", dhit, 0);
    step(); settle();
    check_eq("t3_c1_dWEN", dWEN, 1);
    check_eq("t3_c1_daddr", daddr, 32'h40);
    check_eq("t3_c1_dstore", dstore, 32'h12345678);
    step(); settle();
    check_eq("t3_c2_daddr", daddr, 32'h44);
    check_eq("t3_c2_dstore", dstore, 32'hCAFEF00D);
    step(); settle();
    check_eq("t3_c3_dREN", dREN, 1);
    check_eq("t3_c3_daddr", daddr, 32'h80);
    step(); settle();
    check_eq("t3_c4_daddr", daddr, 32'h84);
    step(); settle();
    check_eq("t3_c5_dhit", dhit, 1);
    check_eq("t3_c5_load", dmemload, 32'h11110000);
    check_eq("t3_wr_cnt", wr_cnt - base, 2);

    // Clean miss on 0xC0 with 3 stall cycles in LD0
    step(); dmemaddr = 32'hC0; dwait = 1'b1; settle();
    check_eq("t4_c0_dhit", dhit, 0);
    for (int c = 1; c <= 3; c++) begin
      step(); settle();
      check_eq($sformatf("t4_c%0d_dREN", c), dREN, 1);
      check_eq($sformatf("t4_c%0d_daddr", c), daddr, 32'hC0);
      check_eq($sformatf("t4_c%0d_dhit", c), dhit, 0);
    end
    step(); dwait = 1'b0; settle();
    check_eq("t4_c4_daddr", daddr, 32'hC0);
    step(); settle();
    check_eq("t4_c5_daddr", daddr, 32'hC4);
    step(); settle();
    check_eq("t4_c6_dhit", dhit, 1);
    check_eq("t4_c6_load", dmemload, 32'h33333333);

    // Write misses to 0x54 (index 2) and 0x68 (index 5) leave them dirty
    step(); dmemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h54; dmemstore = 32'hAAAA0054; settle();
    check_eq("t5_w54_c0_dhit", dhit, 0);
    step(); step(); step(); settle();
    check_eq("t5_w54_c3_dhit", dhit, 1);
    step(); dmemaddr = 32'h68; dmemstore = 32'hBBBB0068; settle();
    check_eq("t5_w68_c0_dhit", dhit, 0);
    step(); step(); step(); settle();
    check_eq("t5_w68_c3_dhit", dhit, 1);

    // Miss on 0x100 with halt raised mid-miss: fill completes, then flush
    step(); dmemWEN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h100; settle();
    check_eq("t5_m_c0_dhit", dhit, 0);
    step(); halt = 1'b1; base = wr_cnt; settle();
    check_eq("t5_m_c1_daddr", daddr, 32'h100);
    step(); settle();
    check_eq("t5_m_c2_daddr", daddr, 32'h104);
    step(); settle();
    check_eq("t5_m_c3_dhit", dhit, 0);
    check_eq("t5_m_c3_dREN", dREN, 0);
    n = 0;
    while (!flushed && n < 100) begin
      step(); settle(); n++;
    end
    check_eq("t5_flushed", flushed, 1);
    check_eq("t5_fl_wr_cnt", wr_cnt - base, 4);
    check_eq("t5_fl_a0", wr_addr[base],   32'h50);
    check_eq("t5_fl_d0", wr_data[base],   32'h50505050);
    check_eq("t5_fl_a1", wr_addr[base+1], 32'h54);
    check_eq("t5_fl_d1", wr_data[base+1], 32'hAAAA0054);
    check_eq("t5_fl_a2", wr_addr[base+2], 32'h68);
    check_eq("t5_fl_d2", wr_data[base+2], 32'hBBBB0068);
    check_eq("t5_fl_a3", wr_addr[base+3], 32'h6C);
    check_eq("t5_fl_d3", wr_data[base+3], 32'h6C6C6C6C);
    step(); halt = 1'b0; step(); step(); settle();
    check_eq("t5_sticky_flushed", flushed, 1);
    check_eq("t5_sticky_dWEN", dWEN, 0);
    check_eq("t5_sticky_dhit", dhit, 0);

    // Reset, refill 0x40, dirty it, then reset during the WB1 of a 0x80 miss
    step(); nRST = 1'b0; dmemREN = 1'b0; #1;
    check_eq("t6_rst_flushed", flushed, 0);
    step(); nRST = 1'b1;
    step(); dmemREN = 1'b1; dmemaddr = 32'h40; settle();
    check_eq("t6_fill_c0_dhit", dhit, 0);
    step(); step(); step(); settle();
    check_eq("t6_fill_c3_dhit", dhit, 1);
    step(); dmemREN = 1'b0; dmemWEN = 1'b1; dmemstore = 32'h77777777; settle();
    check_eq("t6_wr_dhit", dhit, 1);
    step(); dmemWEN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h80; base = wr_cnt; settle();
    step(); settle();
    check_eq("t6_wb0_daddr", daddr, 32'h40);
    step(); settle();
    check_eq("t6_wb1_dWEN", dWEN, 1);
    check_eq("t6_wb1_daddr", daddr, 32'h44);
    nRST = 1'b0; #1;
    check_eq("t6_async_dWEN", dWEN, 0);
    check_eq("t6_async_daddr", daddr, 0);
    check_eq("t6_async_dstore", dstore, 0);
    check_eq("t6_async_dREN", dREN, 0);
    check_eq("t6_wb_logged", wr_cnt - base, 1);
    check_eq("t6_wb_data", wr_data[base], 32'h77777777);
    dmemREN = 1'b0;
    step(); step(); nRST = 1'b1;
    step(); dmemREN = 1'b1; dmemaddr = 32'h40; settle();
    check_eq("t6_post_dhit", dhit, 0);
    step(); settle();
    check_eq("t6_post_dREN", dREN, 1);
    check_eq("t6_post_daddr", daddr, 32'h40);
    step(); step(); settle();
    check_eq("t6_post_load", dmemload, 32'hDEADBEEF);
    step(); dmemREN = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
